// File: rtl/hdd_pwr_seq_pkg.sv
// ----------------------------------------------------------------------------
// hdd_pwr_seq_pkg
//   Shared constants for the staggered HDD spin-up sequencer:
//   - default bay count, spin-up gap and debounce depth
//   - one-hot bay state encoding (OFF / WAIT / ON)
// ----------------------------------------------------------------------------
package hdd_pwr_seq_pkg;

    localparam int DEF_NUM_HDD      = 15;
    localparam int DEF_SPINUP_DELAY = 2;
    localparam int DEF_DEBOUNCE     = 2;

    // One-hot so each output can be taken straight from a single flop.
    typedef enum logic [2:0] {
        HDD_OFF  = 3'b001,
        HDD_WAIT = 3'b010,
        HDD_ON   = 3'b100
    } hdd_state_e;

    localparam int ST_WAIT_BIT = 1;
    localparam int ST_ON_BIT   = 2;

endpackage

// File: rtl/hdd_pwr_slot.sv
// ----------------------------------------------------------------------------
// hdd_pwr_slot
//   One drive bay: two-flop synchronisers on the insert and I2C enable lines,
//   insert debounce counter, and the OFF/WAIT/ON bay state machine.
// Ports
//   CLK_1HZ       in   sequencing clock
//   RESET_N       in   asynchronous active-low reset
//   hdd_insert_l  in   raw bay insert (active-low, asynchronous)
//   pwr_en_l_i2c  in   raw I2C power enable (active-low, asynchronous)
//   grant         in   arbiter selects this bay on the coming edge
//   req           out  debounced insert present and I2C enabled
//   waiting       out  bay is in WAIT (registered state bit)
//   on            out  bay is in ON (registered state bit)
//   hold_done     out  bay will be WAIT or mid-debounce after the coming edge
// ----------------------------------------------------------------------------
module hdd_pwr_slot
    import hdd_pwr_seq_pkg::*;
#(
    parameter int DEBOUNCE = DEF_DEBOUNCE
) (
    input  logic CLK_1HZ,
    input  logic RESET_N,
    input  logic hdd_insert_l,
    input  logic pwr_en_l_i2c,
    input  logic grant,
    output logic req,
    output logic waiting,
    output logic on,
    output logic hold_done
);

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE);

    logic          ins_s1, ins_s2;
    logic          i2c_s1, i2c_s2;
    logic [DW-1:0] deb_cnt;
    hdd_state_e    state;

    assign req = (deb_cnt == DEB_MAX) && !ins_s2 && !i2c_s2;

    always_ff @(posedge CLK_1HZ or negedge RESET_N) begin
        if (!RESET_N) begin
            ins_s1  <= 1'b1;
            ins_s2  <= 1'b1;
            i2c_s1  <= 1'b1;
            i2c_s2  <= 1'b1;
            deb_cnt <= '0;
            state   <= HDD_OFF;
        end else begin
            ins_s1 <= hdd_insert_l;
            ins_s2 <= ins_s1;
            i2c_s1 <= pwr_en_l_i2c;
            i2c_s2 <= i2c_s1;

            if (ins_s2)
                deb_cnt <= '0;
            else if (deb_cnt != DEB_MAX)
                deb_cnt <= deb_cnt + DW'(1);

            // Losing the request always wins over a grant on the same edge.
            unique case (state)
                HDD_OFF:  if (req) state <= HDD_WAIT;
                HDD_WAIT: begin
                    if (!req)
                        state <= HDD_OFF;
                    else if (grant)
                        state <= HDD_ON;
                end
                HDD_ON:   if (!req) state <= HDD_OFF;
                default:  state <= HDD_OFF;
            endcase
        end
    end

    assign waiting = state[ST_WAIT_BIT];
    assign on      = state[ST_ON_BIT];

    // Look-ahead of the next state so SEQ_DONE can be registered on the same
    // edge that finishes the sequence rather than one tick later.
    assign hold_done = ((state == HDD_OFF)  && req)
                    || ((state == HDD_WAIT) && req && !grant)
                    || (!ins_s2 && ((int'(deb_cnt) + 1) < DEBOUNCE));

endmodule

// File: rtl/hdd_pwr_seq.sv
// ----------------------------------------------------------------------------
// hdd_pwr_seq
//   Staggered HDD spin-up sequencer with hot-plug support. Each bay requests
//   power when its insert is debounced and its I2C enable is active; bays are
//   powered one at a time, lowest index first, SPINUP_DELAY ticks apart.
// Ports
//   CLK_1HZ       in   1 Hz sequencing clock
//   RESET_N       in   asynchronous active-low reset
//   HDD_INSERT_L  in   [NUM_HDD] bay insert, active-low
//   PWR_EN_L_I2C  in   [NUM_HDD] I2C power enable, active-low
//   PWR_EN_L      out  [NUM_HDD] load-switch enable, active-low
//   PENDING       out  [NUM_HDD] bay waiting for a grant slot
//   SPINUP_BUSY   out  gap counter nonzero
//   SEQ_DONE      out  boot window over, nothing pending/debouncing, gap zero
// ----------------------------------------------------------------------------
module hdd_pwr_seq
    import hdd_pwr_seq_pkg::*;
#(
    parameter int NUM_HDD      = DEF_NUM_HDD,
    parameter int SPINUP_DELAY = DEF_SPINUP_DELAY,
    parameter int DEBOUNCE     = DEF_DEBOUNCE
) (
    input  logic               CLK_1HZ,
    input  logic               RESET_N,
    input  logic [NUM_HDD-1:0] HDD_INSERT_L,
    input  logic [NUM_HDD-1:0] PWR_EN_L_I2C,
    output logic [NUM_HDD-1:0] PWR_EN_L,
    output logic [NUM_HDD-1:0] PENDING,
    output logic               SPINUP_BUSY,
    output logic               SEQ_DONE
);

    localparam int GW = $clog2(SPINUP_DELAY + 1);
    localparam int BW = $clog2(DEBOUNCE + 4);
    localparam logic [BW-1:0] BOOT_MAX = BW'(DEBOUNCE + 3);

    logic [NUM_HDD-1:0] req_vec, wait_vec, on_vec, hold_vec, grant_vec;
    logic [GW-1:0]      gap, gap_nxt;
    logic [BW-1:0]      boot, boot_nxt;
    logic               granted;

    for (genvar i = 0; i < NUM_HDD; i++) begin : g_slot
        hdd_pwr_slot #(
            .DEBOUNCE (DEBOUNCE)
        ) u_slot (
            .CLK_1HZ      (CLK_1HZ),
            .RESET_N      (RESET_N),
            .hdd_insert_l (HDD_INSERT_L[i]),
            .pwr_en_l_i2c (PWR_EN_L_I2C[i]),
            .grant        (grant_vec[i]),
            .req          (req_vec[i]),
            .waiting      (wait_vec[i]),
            .on           (on_vec[i]),
            .hold_done    (hold_vec[i])
        );
    end

    always_comb begin
        // Isolate the lowest set WAIT bit; only offered when the gap has run out.
        grant_vec = '0;
        if (gap == '0)
            grant_vec = wait_vec & (~wait_vec + NUM_HDD'(1));

        // A selected bay that has just lost its request turns OFF instead of
        // ON; the slot is not consumed, so the next WAIT bay goes on a later edge.
        granted = |(grant_vec & req_vec);

        if (granted)
            gap_nxt = GW'(SPINUP_DELAY - 1);
        else if (gap != '0)
            gap_nxt = gap - GW'(1);
        else
            gap_nxt = gap;

        boot_nxt = (boot == BOOT_MAX) ? boot : boot + BW'(1);
    end

    always_ff @(posedge CLK_1HZ or negedge RESET_N) begin
        if (!RESET_N) begin
            gap      <= GW'(SPINUP_DELAY);
            boot     <= '0;
            SEQ_DONE <= 1'b0;
        end else begin
            gap      <= gap_nxt;
            boot     <= boot_nxt;
            SEQ_DONE <= (boot_nxt == BOOT_MAX) && !(|hold_vec) && (gap_nxt == '0);
        end
    end

    assign PWR_EN_L    = ~on_vec;
    assign PENDING     = wait_vec;
    assign SPINUP_BUSY = (gap != '0);

endmodule
